dec2to4_hold: RTL and testbench

Sequential 2-to-4 decoder: the receiving end of the 4-to-2 priority-encoder path. It accepts a 2-bit code over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. It then pulses `done` and returns to idle. It sits downstream of the priority encoder and turns an encoded request index back into a held one-hot select or grant.

---
 rtl/dec2to4_hold.sv | 217 +++++++++++++++++++++
 tb/tb_dec2to4_hold.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dec2to4_hold.sv
// -----------------------------------------------------------------------------
// dec2to4_hold
//
// Sequential 2-to-4 decoder sitting downstream of the 4-to-2 priority encoder.
// It accepts a 2-bit code (plus an enable) over a valid/ready handshake and
// holds the matching one-hot line for HOLD_CYCLES cycles. It pulses `done` on
// the last cycle of each window and then returns to idle.
//
// Optional feature macro: DEC2TO4_QUEUE_EN
//   Defined   -> a one-entry pending register (code, en, full) lets the next
//                code be accepted while a window is active, so windows run
//                back to back with no idle gap.
//   Undefined -> no pending register. Every window is followed by at least
//                one idle cycle.
//
// Parameters
//   HOLD_CYCLES  cycles each decoded value is held, legal range 1..255
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   in_code/in_en are presented
//   in_ready   out  block can accept this cycle (combinational)
//   in_code    in   encoded index, 0 -> y[0] ... 3 -> y[3]
//   in_en      in   0 holds an all-zero y for a full window ("empty" slot)
//   y          out  decoded output, one-hot or zero (registered)
//   y_valid    out  high on every cycle of a hold window (registered)
//   done       out  one-cycle pulse on the last cycle of a window (registered)
//   dbg_state  out  current FSM state (0 = IDLE, 1 = HOLD)
//
// Handshake: a transfer happens at a rising edge where in_valid && in_ready.
// in_ready depends only on rst, the FSM state and the pending-full flag, and
// never on in_valid. A producer may present data and wait, and it may change
// in_code/in_en freely until the transfer happens.
// -----------------------------------------------------------------------------
module dec2to4_hold #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_code,
  input  logic       in_en,
  output logic [3:0] y,
  output logic       y_valid,
  output logic       done,
  output logic       dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // A window runs from cnt = HOLD_CYCLES-1 down to 0. The cnt == 0 cycle is
  // the done cycle.
  localparam logic [7:0] CNT_RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic       DONE_ON_LOAD = (CNT_RELOAD == 8'd0);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [3:0] y_d;
  logic       y_valid_d;
  logic       done_d;

  logic       xfer;
  logic [3:0] in_onehot;
  logic       load_en;
  logic [3:0] load_y;

  assign xfer      = in_valid && in_ready;
  assign in_onehot = in_en ? (4'b0001 << in_code) : 4'b0000;
  assign dbg_state = state_q;

`ifdef DEC2TO4_QUEUE_EN
  logic       pend_full_q;
  logic       pend_full_d;
  logic [1:0] pend_code_q;
  logic [1:0] pend_code_d;
  logic       pend_en_q;
  logic       pend_en_d;
  logic [3:0] pend_onehot;

  assign pend_onehot = pend_en_q ? (4'b0001 << pend_code_q) : 4'b0000;

  // In IDLE the pending slot is always empty, so this reads as "ready" there.
  // In HOLD it admits exactly one code ahead of the active window.
  assign in_ready = !rst && !pend_full_q;
`else
  assign in_ready = !rst && (state_q == S_IDLE);
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y;
    y_valid_d = y_valid;
    done_d    = 1'b0;
    load_en   = 1'b0;
    load_y    = 4'b0000;
`ifdef DEC2TO4_QUEUE_EN
    pend_full_d = pend_full_q;
    pend_code_d = pend_code_q;
    pend_en_d   = pend_en_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          load_en = 1'b1;
          load_y  = in_onehot;
        end
      end

      S_HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d  = cnt_q - 8'd1;
          // done is registered, so it is raised one cycle ahead of cnt == 0.
          done_d = (cnt_q == 8'd1);
`ifdef DEC2TO4_QUEUE_EN
          if (xfer) begin
            pend_full_d = 1'b1;
            pend_code_d = in_code;
            pend_en_d   = in_en;
          end
`endif
        end else begin
          // Last cycle of the window: chain into the next one or go idle.
`ifdef DEC2TO4_QUEUE_EN
          if (pend_full_q) begin
            load_en     = 1'b1;
            load_y      = pend_onehot;
            pend_full_d = 1'b0;
          end else if (xfer) begin
            // The slot is empty, so the new code bypasses it and starts the
            // next window directly.
            load_en = 1'b1;
            load_y  = in_onehot;
          end else begin
            state_d   = S_IDLE;
            cnt_d     = 8'd0;
            y_d       = 4'b0000;
            y_valid_d = 1'b0;
          end
`else
          state_d   = S_IDLE;
          cnt_d     = 8'd0;
          y_d       = 4'b0000;
          y_valid_d = 1'b0;
`endif
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = 8'd0;
        y_d       = 4'b0000;
        y_valid_d = 1'b0;
      end
    endcase

    // Start a new window. This is shared by the IDLE transfer, the pending
    // reload and the bypass path.
    if (load_en) begin
      state_d   = S_HOLD;
      cnt_d     = CNT_RELOAD;
      y_d       = load_y;
      y_valid_d = 1'b1;
      done_d    = DONE_ON_LOAD;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      y       <= 4'b0000;
      y_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y       <= y_d;
      y_valid <= y_valid_d;
      done    <= done_d;
    end
  end

`ifdef DEC2TO4_QUEUE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full_q <= 1'b0;
      pend_code_q <= 2'd0;
      pend_en_q   <= 1'b0;
    end else begin
      pend_full_q <= pend_full_d;
      pend_code_q <= pend_code_d;
      pend_en_q   <= pend_en_d;
    end
  end
`endif

  // Output invariants: y carries at most one set bit. y and done are quiet
  // outside a window.
  assert property (@(posedge clk) disable iff (rst) $onehot0(y));
  assert property (@(posedge clk) disable iff (rst) !y_valid |-> (y == 4'b0000) && !done);

endmodule

// File: tb/tb_dec2to4_hold.sv
// -----------------------------------------------------------------------------
// tb_dec2to4_hold
//
// Two decoders run side by side: lane 0 has HOLD_CYCLES=4 and lane 1 has
// HOLD_CYCLES=1. The reference model is a per-lane timeline queue of expected
// outputs, with one entry per future cycle.
//
// An accepted code appends HOLD entries to that queue. done is set in the last
// entry. A cycle with no queued entry is expected to be idle.
//
// Expected in_ready follows from the backlog:
//   without the pending slot: ready only when idle with nothing queued;
//   with it: ready while less than one full window is queued.
// -----------------------------------------------------------------------------
module tb_dec2to4_hold;

  localparam int HOLD0 = 4;
  localparam int HOLD1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       in_valid  [2];
  logic [1:0] in_code   [2];
  logic       in_en     [2];
  logic       in_ready  [2];
  logic [3:0] y         [2];
  logic       y_valid   [2];
  logic       done      [2];
  logic       dbg_state [2];

  dec2to4_hold #(.HOLD_CYCLES(HOLD0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_code   (in_code[0]),
    .in_en     (in_en[0]),
    .y         (y[0]),
    .y_valid   (y_valid[0]),
    .done      (done[0]),
    .dbg_state (dbg_state[0])
  );

  dec2to4_hold #(.HOLD_CYCLES(HOLD1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_code   (in_code[1]),
    .in_en     (in_en[1]),
    .y         (y[1]),
    .y_valid   (y_valid[1]),
    .done      (done[1]),
    .dbg_state (dbg_state[1])
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {y[3:0], y_valid, done}
  logic [5:0] exp_q0[$];
  logic [5:0] exp_q1[$];
  int         checks = 0;
  int         errors = 0;
  int         acc_cnt   [2] = '{0, 0};
  logic       ready_exp [2] = '{1'b0, 1'b0};

  function automatic int hold_of(int l);
    return (l == 0) ? HOLD0 : HOLD1;
  endfunction

  function automatic int q_size(int l);
    return (l == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void q_push(int l, logic [5:0] e);
    if (l == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endfunction

  function automatic logic [5:0] q_pop(int l);
    if (l == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic void q_clear(int l);
    if (l == 0) exp_q0.delete();
    else        exp_q1.delete();
  endfunction

  // Rising edge: the model records accepted codes and resets.
  // Falling edge: the monitor pops one expected cycle per lane and compares.
  always @(posedge clk or negedge clk) begin
    logic [5:0] cur;
    logic [3:0] code_y;
    if (clk) begin
      for (int l = 0; l < 2; l++) begin
        if (rst) begin
          q_clear(l);
        end else if (in_valid[l] && ready_exp[l]) begin
          code_y = in_en[l] ? 4'(2 ** in_code[l]) : 4'b0000;
          acc_cnt[l]++;
          for (int i = 0; i < hold_of(l); i++)
            q_push(l, {code_y, 1'b1, (i == hold_of(l) - 1)});
        end
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        cur = (q_size(l) > 0) ? q_pop(l) : 6'b000000;
        checks++;
        if ({y[l], y_valid[l], done[l], dbg_state[l]} !== {cur, cur[1]}) begin
          errors++;
          $display("FAIL lane%0d outputs @%0t: got y=%b y_valid=%b done=%b state=%b, exp y=%b y_valid=%b done=%b state=%b",
                   l, $time, y[l], y_valid[l], done[l], dbg_state[l],
                   cur[5:2], cur[1], cur[0], cur[1]);
        end
`ifdef DEC2TO4_QUEUE_EN
        ready_exp[l] = !rst && (q_size(l) < hold_of(l));
`else
        ready_exp[l] = !rst && (q_size(l) == 0) && !cur[1];
`endif
        checks++;
        if (in_ready[l] !== ready_exp[l]) begin
          errors++;
          $display("FAIL lane%0d in_ready @%0t: got %b, exp %b", l, $time, in_ready[l], ready_exp[l]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a code and waits until the handshake completes. in_valid is left
  // high, so the caller can chain codes back to back.
  task automatic send(input int l, input logic [1:0] code, input logic en);
    int start;
    start       = acc_cnt[l];
    in_valid[l] = 1'b1;
    in_code[l]  = code;
    in_en[l]    = en;
    for (int n = 0; n < 64 && acc_cnt[l] == start; n++) tick();
    if (acc_cnt[l] == start) begin
      $display("FAIL lane%0d send_timeout: code %0d not accepted within 64 cycles", l, code);
      $fatal(1, "handshake stalled");
    end
  endtask

  task automatic idle_lane(input int l, input int cycles);
    in_valid[l] = 1'b0;
    repeat (cycles) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int l = 0; l < 2; l++) begin
      in_valid[l] = 1'b0;
      in_code[l]  = 2'd0;
      in_en[l]    = 1'b0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single code.
    send(0, 2'd2, 1'b1);
    idle_lane(0, 6);

    // Sweep 0..3 with in_valid held high.
    for (int c = 0; c < 4; c++) send(0, 2'(c), 1'b1);
    idle_lane(0, 6);

    // Empty slot.
    send(0, 2'd3, 1'b0);
    idle_lane(0, 6);

    // One-cycle windows.
    send(1, 2'd1, 1'b1);
    send(1, 2'd3, 1'b1);
    idle_lane(1, 4);

    // Reset on the second hold cycle.
    send(0, 2'd1, 1'b1);
    in_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Codes offered back to back (chains without gaps when the pending slot exists).
    send(0, 2'd0, 1'b1);
    send(0, 2'd3, 1'b1);
    send(0, 2'd2, 1'b1);
    idle_lane(0, 16);

    // Random traffic on both lanes, with occasional resets.
    repeat (600) begin
      for (int l = 0; l < 2; l++) begin
        in_valid[l] = ($urandom_range(0, 2) != 0);
        in_code[l]  = 2'($urandom_range(0, 3));
        in_en[l]    = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
